// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial UART transmitter. Parallel words arrive on a valid/ready handshake.
// They leave as start / LSB-first data / optional parity / stop frames at a
// fixed bit period of CLKS_PER_BIT clocks. A one-word holding register sits in
// front of the shifter, so a word that is already waiting follows the previous
// frame with no idle gap.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit follows the data bits.
//                      PARITY_ODD selects its sense. When undefined, the
//                      parity logic is absent and PARITY_ODD only takes part
//                      in the parameter sanity check.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   DATA_WIDTH    payload bits per frame
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    1 = odd parity, 0 = even parity
//
// Ports:
//   clk        sole clock; all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   data       word to transmit, sampled on acceptance
//   valid      the producer has a word on data
//   ready      the holding register can take a word this cycle
//   tx_out     serial line, driven from a flop, idles high
//   busy       high while a frame is on the line (START through last STOP)
//   done       high for the last clock of each frame's final stop bit
//   fsm_state  current FSM state encoding (debug / checker visibility)
//
// Handshake: a word transfers on a rising clk edge where valid & ready are
// both high. The producer keeps valid and data stable until that edge.
// valid while ready is low is not a transfer. ready is the holding register's
// empty flag. It also rises during the final stop-bit clock of a frame when
// the held word is being moved into the shifter on that same edge; the
// register is then refilled with the new word.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 870,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            fsm_state
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam bit CFG_OK = (CLKS_PER_BIT >= 2) && (DATA_WIDTH >= 1) &&
                          (STOP_BITS == 1 || STOP_BITS == 2) &&
                          (PARITY_ODD == 0 || PARITY_ODD == 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("uart_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shifter;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  par_bit;
  logic                  bit_end;
  logic                  stop_end;
  logic                  load;
  logic                  accept;
  logic                  tx_next;

  assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
  assign stop_end = (state == S_STOP) && bit_end &&
                    (bit_cnt == CW'(STOP_BITS - 1));
  assign accept   = valid & ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. load marks the edge where the held word moves into
  // the shifter. This happens either from IDLE or straight out of the last
  // stop bit, which is what makes back-to-back frames gapless.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          state_next = S_START;
          load       = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == CW'(DATA_WIDTH - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
      S_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end) state_next = S_STOP;
`else
        state_next = S_IDLE;
`endif
      end
      S_STOP: begin
        if (stop_end) begin
          if (hold_full) begin
            state_next = S_START;
            load       = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. tx_next is the line level for the bit that starts on the
  // coming edge. It is registered into tx_out so the pin never glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_next = shifter;
    if (load) begin
      shift_next = hold_data;
    end else if (state == S_DATA && bit_end) begin
      shift_next = shifter >> 1;
    end

    tx_next = 1'b1;
    case (state_next)
      S_IDLE:   tx_next = 1'b1;
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = par_bit;
      S_STOP:   tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase

    busy      = (state != S_IDLE);
    done      = stop_end;
    // While the last stop clock moves the held word out, the register can
    // take a new word on that same edge.
    ready     = ~hold_full | (stop_end & hold_full);
    fsm_state = state;
  end

  // ---------------------------------------------------------------------------
  // Bit timer and bit counter. The timer runs 0..CLKS_PER_BIT-1 within each
  // bit and is held at zero in IDLE, so a START entered from IDLE lasts a
  // full period. bit_cnt counts data bits in DATA and stop bits in STOP. It
  // clears on every state change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == S_IDLE || bit_end) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (bit_end && (state == S_DATA || state == S_STOP)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: holding register, shifter, parity and line flop.
  // A new word can arrive on the same edge that drains the register.
  // accept then wins, and the register stays full with the new word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      tx_out    <= 1'b1;
    end else begin
      if (accept) begin
        hold_data <= data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      shifter <= shift_next;
      tx_out  <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // The parity of the payload is captured with the word at load time, because
  // the shifter no longer holds the whole word once it reaches the parity bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^hold_data) ^ (PARITY_ODD != 0);
    end
  end
`else
  assign par_bit = 1'b1;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx at CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1.
// The line is sampled on every falling edge. The expected per-clock level of
// tx_out is queued in exp_q and compared one entry per clock. Edge numbers are
// counted in cyc, the number of rising edges seen so far.
// Define UART_TX_PARITY_EN for both the RTL and this file to cover parity.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME = BITS * CPB;

  // ---- clock / reset --------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx_out;
  logic       busy;
  logic       done;
  logic [2:0] fsm_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done),
    .fsm_state(fsm_state)
  );

`ifdef UART_TX_PARITY_EN
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] state_o;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (1)
  ) u_dut_odd (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .valid    (valid),
    .ready    (ready_o),
    .tx_out   (tx_o),
    .busy     (busy_o),
    .done     (done_o),
    .fsm_state(state_o)
  );
`endif

  // ---- scoreboard state -----------------------------------------------------
  logic [0:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] words [0:3];
  int         acc_edge [0:3];

  // Expected line level for bit b of a frame carrying w (even parity sense).
  function automatic logic frame_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // Queue the per-clock line levels for n consecutive frames from words[].
  task automatic queue_frames(input int n);
    exp_q.delete();
    for (int i = 0; i < n * FRAME; i++) begin
      exp_q.push_back(frame_bit(words[i / FRAME], (i % FRAME) / CPB));
    end
  endtask

  // ---- driver ---------------------------------------------------------------
  // Offers words[0..n-1] in order and records the edge at which each one is
  // accepted. Called at a falling edge.
  task automatic drive_words(input int n);
    int waited;
    for (int k = 0; k < n; k++) begin
      data   = words[k];
      valid  = 1'b1;
      waited = 0;
      while (ready !== 1'b1 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (ready !== 1'b1) begin
        total++; bad++;
        $display("FAIL drive_timeout word=%0d ready=%b required=1", k, ready);
        valid = 1'b0;
        return;
      end
      acc_edge[k] = cyc + 1;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
  endtask

  // ---- tests ----------------------------------------------------------------
  task automatic test_reset();
    valid = 1'b1;
    data  = 8'hEE;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (tx_out !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          fsm_state !== 3'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got tx=%b rdy=%b busy=%b done=%b st=%0d required 1 1 0 0 0",
                 i, tx_out, ready, busy, done, fsm_state);
      end
    end
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || fsm_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_no_transfer got tx=%b busy=%b st=%0d required 1 0 0", tx_out, busy, fsm_state);
    end
  endtask

  task automatic test_single_frame();
    int c0;
    logic [0:0] e;
    words[0] = 8'hA5;
    queue_frames(1);
    c0 = cyc;
    fork
      drive_words(1);
      begin
        @(negedge clk);  // after acceptance edge c0+1: line not yet low
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
          bad++;
          $display("FAIL a5_pre_start got tx=%b busy=%b rdy=%b required 1 0 0", tx_out, busy, ready);
        end
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          total++;
          if (tx_out !== e) begin
            bad++;
            $display("FAIL a5_line i=%0d got=%b required=%b", i, tx_out, e);
          end
          total++;
          if (done !== (i == FRAME - 1) || busy !== 1'b1) begin
            bad++;
            $display("FAIL a5_done_busy i=%0d got done=%b busy=%b required done=%b busy=1",
                     i, done, busy, (i == FRAME - 1));
          end
          if (i == 0) begin
            total++;
            if (ready !== 1'b1) begin
              bad++;
              $display("FAIL a5_ready_after_e1 got=%b required=1", ready);
            end
          end
        end
        @(negedge clk);
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL a5_post_idle got tx=%b busy=%b done=%b required 1 0 0", tx_out, busy, done);
        end
      end
    join
    total++;
    if (acc_edge[0] !== c0 + 1) begin
      bad++;
      $display("FAIL a5_accept_edge got=%0d required=%0d", acc_edge[0], c0 + 1);
    end
  endtask

  // Runs n frames back to back from words[] and checks the line, done and busy
  // on every clock. It also checks ready in the middle of frame 0 and the
  // acceptance edges against the expected values.
  task automatic test_back_to_back(input int n, input string tag);
    int c0;
    logic [0:0] e;
    queue_frames(n);
    c0 = cyc;
    fork
      drive_words(n);
      begin
        @(negedge clk);
        for (int i = 0; i < n * FRAME; i++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          total++;
          if (tx_out !== e) begin
            bad++;
            $display("FAIL %s_line i=%0d got=%b required=%b", tag, i, tx_out, e);
          end
          total++;
          if (done !== ((i % FRAME) == FRAME - 1) || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_busy i=%0d got done=%b busy=%b required done=%b busy=1",
                     tag, i, done, busy, ((i % FRAME) == FRAME - 1));
          end
          if (i == FRAME / 2) begin
            total++;
            if (ready !== 1'b0) begin
              bad++;
              $display("FAIL %s_ready_held got=%b required=0", tag, ready);
            end
          end
        end
        @(negedge clk);
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s_post_idle got tx=%b busy=%b required 1 0", tag, tx_out, busy);
        end
      end
    join
    total++;
    if (acc_edge[1] !== c0 + 3) begin
      bad++;
      $display("FAIL %s_accept2 got=%0d required=%0d", tag, acc_edge[1], c0 + 3);
    end
    if (n > 2) begin
      total++;
      if (acc_edge[2] !== c0 + 2 + FRAME) begin
        bad++;
        $display("FAIL %s_accept3 got=%0d required=%0d", tag, acc_edge[2], c0 + 2 + FRAME);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    logic [0:0] e;
    words[0] = 8'h3C;
    words[1] = 8'h55;  // held when reset hits; must be discarded
    c0 = cyc;
    fork
      drive_words(2);
      while (cyc < c0 + 19) @(negedge clk);
    join
    total++;
    if (busy !== 1'b1 || fsm_state !== 3'd2) begin
      bad++;
      $display("FAIL midrst_pre got busy=%b st=%0d required 1 2", busy, fsm_state);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || fsm_state !== 3'd0) begin
      bad++;
      $display("FAIL midrst_async got tx=%b busy=%b rdy=%b done=%b st=%0d required 1 0 1 0 0",
               tx_out, busy, ready, done, fsm_state);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    words[0] = 8'h81;
    queue_frames(1);
    fork
      drive_words(1);
      begin
        @(negedge clk);
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          total++;
          if (tx_out !== e) begin
            bad++;
            $display("FAIL midrst_81_line i=%0d got=%b required=%b", i, tx_out, e);
          end
        end
      end
    join
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      total++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midrst_no_stale i=%0d got tx=%b busy=%b required 1 0", i, tx_out, busy);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int c0;
    logic [0:0] e;
    words[0] = 8'h07;
    queue_frames(1);
    c0 = cyc;
    fork
      drive_words(1);
      begin
        @(negedge clk);
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          total++;
          if (tx_out !== e) begin
            bad++;
            $display("FAIL par_even_line i=%0d got=%b required=%b", i, tx_out, e);
          end
          total++;
          if (tx_o !== ((i / CPB == 9) ? 1'b0 : e)) begin
            bad++;
            $display("FAIL par_odd_line i=%0d got=%b", i, tx_o);
          end
          if (i / CPB == 9) begin
            total++;
            if (tx_out !== 1'b1 || tx_o !== 1'b0) begin
              bad++;
              $display("FAIL par_bit got even=%b odd=%b required 1 0", tx_out, tx_o);
            end
          end
          total++;
          if (done !== (i == 43) || done_o !== (i == 43)) begin
            bad++;
            $display("FAIL par_done i=%0d got=%b/%b required=%b", i, done, done_o, (i == 43));
          end
        end
      end
    join
  endtask
`endif

  // ---- watchdog -------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---- sequence and report --------------------------------------------------
  initial begin
    test_reset();
    test_single_frame();
    words[0] = 8'h00;
    words[1] = 8'hFF;
    test_back_to_back(2, "b2b");
    words[0] = 8'h12;
    words[1] = 8'h34;
    words[2] = 8'h56;
    test_back_to_back(3, "holdoff");
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the UART receiver. Accepts parallel words over a valid/ready handshake and emits 8N1-style frames (start, LSB-first data, optional parity, stop) at a fixed bit period set by `CLKS_PER_BIT`. A one-word holding register sits in front of the shifter so consecutive frames go out back-to-back with no idle gap. Sits between the host-side byte producer and the board-level TX pin.

## Interface
- `CLKS_PER_BIT`, 870, clock cycles per serial bit; legal range ≥ 2
- `DATA_WIDTH`, 8, bits per frame payload
- `STOP_BITS`, 1, stop bits per frame; 1 or 2
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even; ignored unless parity is compiled in
- `clk`  in  1  sole clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `data`  in  DATA_WIDTH  word to transmit, sampled on acceptance
- `valid`  in  1  producer has a word on `data`
- `ready`  out  1  holding register empty; transfer occurs on a rising edge with `valid & ready`
- `tx_out`  out  1  serial line, idles high
- `busy`  out  1  high while a frame is on the line (START through last STOP)
- `done`  out  1  one-cycle pulse at the end of each frame's last stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `tx_out`=1. If holding register full, load shifter, clear holding register, go START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx_out`=shifter[0]; shift right at each bit boundary; after `DATA_WIDTH` bits go PARITY or STOP.
- PARITY: `tx_out`=XOR of payload, inverted when `PARITY_ODD`=1; one bit period, then STOP.
- STOP: `tx_out`=1 for `STOP_BITS` bit periods. At end: pulse `done`; if holding register full, load shifter and go directly to START; else IDLE.
- Bit timer: counter of width clog2(`CLKS_PER_BIT`), reloads at each bit boundary; bit counter width clog2(`DATA_WIDTH`+1).
- `ready` = holding register empty (combinational from a flop). Acceptance writes `data` into the holding register.
- Producer holds `valid`/`data` stable until accepted; `valid` with `ready`=0 is not a transfer.
- Acceptance in the same cycle the shifter drains the holding register is legal: the register is refilled, and the new word is the next frame.
- `tx_out` is driven from a flop (glitch-free pin).
- Reset values: `tx_out`=1, `ready`=1, `busy`=0, `done`=0, FSM=IDLE, holding register empty. Reset mid-frame aborts immediately, with the line high asynchronously; the held word is discarded.

## Timing
- Word accepted at edge E0 while IDLE: `tx_out` falls at E1; `busy` rises at E1; `ready` high again after E1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. Frame = (1+`DATA_WIDTH`+P+`STOP_BITS`)·`CLKS_PER_BIT` cycles, where P=1 with parity compiled in, else 0.
- `done` is high for the single cycle ending at the last stop-bit boundary edge. On that same edge `busy` falls, unless a held word exists, in which case the next start bit begins with zero idle cycles.
- Maximum throughput is one word per frame time. A second word may be accepted any time after E1.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity bit are present; frame is one bit longer; `PARITY_ODD` selects the sense.
- Not defined: no parity logic; DATA goes directly to STOP; `PARITY_ODD` is unused.

## Test plan
- Reset asserted low for 3 cycles with `valid`=1 -> `tx_out`=1, `ready`=1, `busy`=0, `done`=0 throughout; no transfer.
- `CLKS_PER_BIT`=4, send 0xA5 -> line carries 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; start falls 1 cycle after acceptance; `done` pulses at cycle 40 after the fall.
- Send 0x00 then 0xFF, second `valid` asserted immediately -> second accepted during the first frame, `ready`=0 until it drains, the second start bit follows the first stop bit with 0 idle cycles, 2 `done` pulses 40 cycles apart.
- Third word offered while the holding register is full -> `ready`=0, word held off, then accepted exactly at the edge the shifter loads word 2; all three bytes appear in order.
- With `UART_TX_PARITY_EN`, 0x07 -> parity bit 1 (even) and 0 (`PARITY_ODD`=1); frame length 44 cycles at `CLKS_PER_BIT`=4.
- Reset pulsed during data bit 3 of 0x3C -> `tx_out`=1 immediately, `busy`=0; the next frame, 0x81, is transmitted cleanly.
